// File: rtl/awp_seq.sv
// FPU micro-sequencer: operand load, memory read, execute, writeback, flag update, done; no backpressure, efp dropped while busy.
// Outputs are registered decodes of the next state, so each appears the edge after the causing input, with no input-to-output path.
module awp_seq (
    input  logic       __clk,
    input  logic       clm,
    input  logic       efp,
    input  logic [7:9] ir,
    input  logic       nrf,
    input  logic       ok,
    input  logic       alarm,
    input  logic       exe_done,
    input  logic       fault,
    output logic       rlp,
    output logic [0:1] lp,
    output logic       read,
    output logic       strob,
    output logic       wrr,
    output logic       ustr,
    output logic       ekc,
    output logic       busy,
    output logic       err
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADR = 3'd1,
        MEMRD = 3'd2,
        EXEC  = 3'd3,
        STORE = 3'd4,
        FLAGS = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] n_q, n_d;
    logic [1:0] k_q, k_d;
    logic       nrf_q, nrf_d;
    logic       err_q, err_d;
    logic [7:0] wd_q, wd_d;

    logic       rlp_q, read_q, strob_q, wrr_q, ustr_q, ekc_q, busy_q;
    logic [1:0] lp_q;
    logic       rlp_d, read_d, strob_d, wrr_d, ustr_d, ekc_d, busy_d;
    logic [1:0] lp_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        k_d     = k_q;
        nrf_d   = nrf_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (efp) begin
                    nrf_d   = nrf;
                    if (nrf || ir[7])        n_d = 2'd3;
                    else if (ir < 3'd2)      n_d = 2'd2;
                    else                     n_d = 2'd1;
                    k_d     = (nrf || ir[7]) ? 2'd3 : 2'd2;
                    err_d   = 1'b0;
                    cnt_d   = 2'd0;
                    state_d = LOADR;
                end
            end
            LOADR: begin
                if (cnt_q == n_q - 2'd1) begin
                    cnt_d   = 2'd0;
                    wd_d    = 8'd0;
                    state_d = nrf_q ? EXEC : MEMRD;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            MEMRD: begin
                // an abort outranks an acknowledge arriving on the same edge
                if (alarm) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (ok) begin
                    if (cnt_q == n_q - 2'd1) begin
                        cnt_d   = 2'd0;
                        wd_d    = 8'd0;
                        state_d = EXEC;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            EXEC: begin
                if (exe_done) begin
                    cnt_d   = 2'd0;
                    state_d = fault ? FLAGS : STORE;
                end else if (wd_q == 8'hFF) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            STORE: begin
                if (cnt_q == k_q - 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = FLAGS;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            FLAGS:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A single-operand load reads only r2; otherwise indices count up from r1.
    always_comb begin
        rlp_d   = 1'b0;
        lp_d    = 2'd0;
        read_d  = 1'b0;
        strob_d = 1'b0;
        wrr_d   = 1'b0;
        ustr_d  = 1'b0;
        ekc_d   = 1'b0;
        busy_d  = (state_d != IDLE);
        case (state_d)
            LOADR: begin
                rlp_d = 1'b1;
                lp_d  = (n_d == 2'd1) ? 2'd2 : cnt_d + 2'd1;
            end
            MEMRD:   read_d  = 1'b1;
            EXEC:    strob_d = (wd_d == 8'd0);
            STORE: begin
                wrr_d = 1'b1;
                lp_d  = cnt_d + 2'd1;
            end
            FLAGS:   ustr_d  = 1'b1;
            DONE:    ekc_d   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge __clk) begin
        if (clm) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            n_q     <= 2'd0;
            k_q     <= 2'd0;
            nrf_q   <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= 8'd0;
            rlp_q   <= 1'b0;
            lp_q    <= 2'd0;
            read_q  <= 1'b0;
            strob_q <= 1'b0;
            wrr_q   <= 1'b0;
            ustr_q  <= 1'b0;
            ekc_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            k_q     <= k_d;
            nrf_q   <= nrf_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            rlp_q   <= rlp_d;
            lp_q    <= lp_d;
            read_q  <= read_d;
            strob_q <= strob_d;
            wrr_q   <= wrr_d;
            ustr_q  <= ustr_d;
            ekc_q   <= ekc_d;
            busy_q  <= busy_d;
        end
    end

    assign rlp   = rlp_q;
    assign lp    = lp_q;
    assign read  = read_q;
    assign strob = strob_q;
    assign wrr   = wrr_q;
    assign ustr  = ustr_q;
    assign ekc   = ekc_q;
    assign busy  = busy_q;
    assign err   = err_q;
endmodule

// File: tb/tb_awp_seq.sv
// Bench for awp_seq: a sequential per-operation reference walks each phase and publishes the expected
// output word for every cycle; a negedge process compares it and also checks a few literal measurements.
module tb_awp_seq;
    logic       __clk = 1'b0;
    logic       clm, efp, nrf, ok, alarm, exe_done, fault;
    logic [7:9] ir;
    logic       rlp, read, strob, wrr, ustr, ekc, busy, err;
    logic [0:1] lp;

    awp_seq dut (
        .__clk(__clk), .clm(clm), .efp(efp), .ir(ir), .nrf(nrf), .ok(ok), .alarm(alarm),
        .exe_done(exe_done), .fault(fault), .rlp(rlp), .lp(lp), .read(read), .strob(strob),
        .wrr(wrr), .ustr(ustr), .ekc(ekc), .busy(busy), .err(err)
    );

    always #5 __clk = ~__clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic       chk_en = 1'b0;
    logic [9:0] exp_vec = '0;
    logic       lit_req = 1'b0;
    int         lit_act = 0;
    int         lit_exp = 0;
    string      lit_name = "";
    int         cyc_n = 0;
    logic       m_err = 1'b0;

    int   t_rlp_seq, t_wrr_seq, t_strob, t_ekc, t_read, t_ustr, t_wrr;
    int   strob_cyc, ekc_cyc, efp_cyc;
    logic ekc_err;

    logic [9:0] dut_vec;
    assign dut_vec = {rlp, lp, read, strob, wrr, ustr, ekc, busy, err};

    always @(negedge __clk) begin
        if (chk_en) begin
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL outputs cyc=%0d got %b expected %b (rlp,lp,read,strob,wrr,ustr,ekc,busy,err)",
                         cyc_n, dut_vec, exp_vec);
            end
        end
        if (lit_req) begin
            vectors++;
            if (lit_act != lit_exp) begin
                miscompares++;
                $display("FAIL %s: got %0d expected %0d", lit_name, lit_act, lit_exp);
            end
        end
    end

    // f = {rlp, read, strob, wrr, ustr, ekc, busy}
    function automatic logic [9:0] mk(input logic [6:0] f, input logic [1:0] l, input logic e);
        return {f[6], l, f[5:0], e};
    endfunction

    task automatic tick(input logic [9:0] e);
        exp_vec = e;
        chk_en  = 1'b1;
        if (rlp) t_rlp_seq = t_rlp_seq * 10 + int'(lp);
        if (wrr) begin
            t_wrr++;
            t_wrr_seq = t_wrr_seq * 10 + int'(lp);
        end
        if (strob) begin
            if (t_strob == 0) strob_cyc = cyc_n;
            t_strob++;
        end
        if (read) t_read++;
        if (ustr) t_ustr++;
        if (ekc) begin
            t_ekc++;
            ekc_cyc = cyc_n;
            ekc_err = err;
        end
        @(posedge __clk);
        #1;
        cyc_n++;
    endtask

    task automatic noise();
        efp      = 1'($urandom_range(0, 1));
        ir       = 3'($urandom_range(0, 7));
        nrf      = 1'($urandom_range(0, 1));
        ok       = 1'($urandom_range(0, 1));
        exe_done = 1'($urandom_range(0, 1));
        fault    = 1'($urandom_range(0, 1));
        alarm    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            efp = 1'b0;
            tick(mk(7'b0000000, 2'd0, m_err));
        end
    endtask

    task automatic lit(input string name, input int act, input int ex);
        lit_name = name;
        lit_act  = act;
        lit_exp  = ex;
        lit_req  = 1'b1;
        idle(1);
        lit_req  = 1'b0;
    endtask

    // One instruction: ok_gap<0 / exe_lat<0 select random timing; alarm_word is the word whose ok carries alarm.
    task automatic run_op(input int ir_v, input bit nrf_v, input int ok_gap, input int exe_lat,
                          input bit flt, input int alarm_word, input bit rst_store);
        int n, k, got, waitc, wd, lpv;
        bit okn, aln, den, aborted;
        n = nrf_v ? 3 : (ir_v < 2) ? 2 : (ir_v < 4) ? 1 : 3;
        k = (nrf_v || ir_v >= 4) ? 3 : 2;
        t_rlp_seq = 0; t_wrr_seq = 0; t_strob = 0; t_ekc = 0; t_read = 0; t_ustr = 0; t_wrr = 0;
        strob_cyc = -1; ekc_cyc = -1; ekc_err = 1'b0;
        den = 1'b0;

        noise();
        efp = 1'b1;
        ir  = ir_v[2:0];
        nrf = nrf_v;
        efp_cyc = cyc_n;
        tick(mk(7'b0000000, 2'd0, m_err));
        m_err = 1'b0;

        for (int i = 0; i < n; i++) begin
            noise();
            lpv = (n == 1) ? 2 : i + 1;
            tick(mk(7'b1000001, 2'(lpv), 1'b0));
        end

        aborted = 1'b0;
        if (!nrf_v) begin
            got = 0;
            waitc = 0;
            while (got < n) begin
                noise();
                okn = (ok_gap < 0) ? (($urandom_range(0, 2) == 0) || waitc >= 6) : (waitc == ok_gap);
                aln = okn && (got == alarm_word);
                ok = okn;
                alarm = aln;
                tick(mk(7'b0100001, 2'd0, 1'b0));
                alarm = 1'b0;
                if (aln) begin
                    aborted = 1'b1;
                    break;
                end
                if (okn) begin
                    got++;
                    waitc = 0;
                end else begin
                    waitc++;
                end
            end
        end

        if (!aborted) begin
            wd = 0;
            while (1) begin
                noise();
                den = (exe_lat < 0) ? ($urandom_range(0, 4) == 0) : (wd == exe_lat);
                exe_done = den;
                if (den) fault = flt;
                tick(mk({2'b00, (wd == 0), 4'b0001}, 2'd0, 1'b0));
                if (den || wd == 255) break;
                wd++;
            end
            if (!den) begin
                aborted = 1'b1;
            end else begin
                if (!flt) begin
                    for (int i = 0; i < k; i++) begin
                        noise();
                        if (rst_store && i == 1) begin
                            clm = 1'b1;
                            efp = 1'b1;
                        end
                        tick(mk(7'b0001001, 2'(i + 1), 1'b0));
                        if (rst_store && i == 1) begin
                            clm = 1'b0;
                            m_err = 1'b0;
                            return;
                        end
                    end
                end
                noise();
                tick(mk(7'b0000101, 2'd0, 1'b0));
            end
        end

        if (aborted) m_err = 1'b1;
        noise();
        tick(mk(7'b0000011, 2'd0, m_err));
    endtask

    initial begin
        int ir_r, aw;
        bit nrf_r, flt_r;
        clm = 1'b1; efp = 1'b1; ir = 3'd0; nrf = 1'b0; ok = 1'b0; alarm = 1'b0;
        exe_done = 1'b0; fault = 1'b0;
        @(posedge __clk);
        #1;
        tick(mk(7'b0000000, 2'd0, 1'b0));
        tick(mk(7'b0000000, 2'd0, 1'b0));
        clm = 1'b0;
        efp = 1'b0;
        idle(2);

        run_op(4, 1'b0, 2, 5, 1'b0, -1, 1'b0);
        lit("af_rlp_lp_seq", t_rlp_seq, 123);
        lit("af_wrr_lp_seq", t_wrr_seq, 123);
        lit("af_strob_count", t_strob, 1);
        lit("af_read_cycles", t_read, 9);
        lit("af_ekc_count", t_ekc, 1);

        run_op(2, 1'b0, 1, 3, 1'b0, -1, 1'b0);
        lit("mw_rlp_lp_seq", t_rlp_seq, 2);
        lit("mw_wrr_lp_seq", t_wrr_seq, 12);
        lit("mw_read_cycles", t_read, 2);

        run_op(6, 1'b1, -1, 0, 1'b0, -1, 1'b0);
        lit("nrf_efp_to_ekc_cycles", ekc_cyc - efp_cyc + 1, 10);
        lit("nrf_read_cycles", t_read, 0);

        run_op(7, 1'b0, 0, 2, 1'b1, -1, 1'b0);
        lit("df_fault_wrr_count", t_wrr, 0);
        lit("df_fault_ustr_count", t_ustr, 1);
        lit("df_fault_ekc_count", t_ekc, 1);

        run_op(0, 1'b0, 0, 4, 1'b0, 1, 1'b0);
        lit("ad_alarm_strob_count", t_strob, 0);
        lit("ad_alarm_read_cycles", t_read, 2);
        lit("ad_alarm_err_at_ekc", int'(ekc_err), 1);
        idle(3);

        run_op(5, 1'b0, 0, 1, 1'b0, -1, 1'b1);
        idle(2);
        lit("reset_store_ekc_count", t_ekc, 0);
        run_op(3, 1'b0, 1, 2, 1'b0, -1, 1'b0);
        lit("after_reset_ekc_count", t_ekc, 1);
        lit("after_reset_err_at_ekc", int'(ekc_err), 0);

        run_op(1, 1'b0, 0, 100000, 1'b0, -1, 1'b0);
        lit("watchdog_strob_to_ekc", ekc_cyc - strob_cyc, 256);
        lit("watchdog_err_at_ekc", int'(ekc_err), 1);
        idle(2);

        for (int t = 0; t < 40; t++) begin
            ir_r  = int'($urandom_range(0, 7));
            nrf_r = ($urandom_range(0, 3) == 0);
            flt_r = ($urandom_range(0, 3) == 0);
            aw    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
            run_op(ir_r, nrf_r, -1, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 10)),
                   flt_r, aw, 1'b0);
            idle(int'($urandom_range(1, 3)));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
